eth_rtt_meter: RTL and testbench
================================

# eth_rtt_meter

Receive-side measurement stage directly downstream of the Ethernet frame parser (`eth_axis_rx`), in place of a plain pattern receiver. It consumes parsed Ethernet frames and keeps only the test frames addressed to this node with EtherType `ETH_TYPE`. From each kept frame it extracts the embedded packet index and transmit timestamp, checks the payload pattern and length, and computes round-trip time against the free-running 1 µs timestamp. It keeps min/max/last RTT and saturating frame and error counters, which are exposed for ILA/debug.

## Interface
Parameters:
- `DATA_LENGTH`, 256: expected payload bytes per test frame; must be at least 4.
- `ETH_TYPE`, 16'h88B6: EtherType of accepted test frames.

Ports:
- `clk` in 1: 125 MHz logic clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `local_mac` in 48: this node's MAC; frames whose dest differs are dropped.
- `timestamp` in 16: free-running µs counter, wraps at 2^16.
- `s_eth_hdr_valid` in 1 / `s_eth_hdr_ready` out 1: header handshake.
- `s_eth_dest_mac` in 48, `s_eth_src_mac` in 48, `s_eth_type` in 16: header fields, qualified by `s_eth_hdr_valid`.
- `s_eth_payload_axis_tdata` in 8, `_tvalid` in 1, `_tready` out 1, `_tlast` in 1, `_tuser` in 1: payload stream.
- `rtt_valid` out 1: one-cycle pulse when a good frame has been measured.
- `rtt_last`, `rtt_min`, `rtt_max` out 16: RTT statistics in µs.
- `frame_count` out 16: accepted test frames, good or bad; saturating.
- `err_count` out 16: frames with length, pattern or tuser error; saturating.
- `seq_err_count` out 16: packet-index discontinuities; saturating.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
Payload format (byte offsets from payload start):
- Bytes 0–1: packet index `idx`, big-endian.
- Bytes 2–3: transmit timestamp `ts`, big-endian.
- Byte k, for 4 ≤ k < `DATA_LENGTH`: `(k + idx[7:0]) mod 256`.

State machine:
- IDLE: `s_eth_hdr_ready`=1, `tready`=0.
  - On header handshake, if `type==ETH_TYPE` and `dest==local_mac`, go to RECV.
  - Otherwise go to DROP.
- RECV: `tready`=1; 16-bit byte counter starting at 0.
  - Bytes 0–3 latch `idx` and `ts`.
  - For k ≥ 4, compare each byte against the pattern; any mismatch sets the sticky `bad` flag.
  - `tuser`=1 on any beat sets `bad`.
  - Beats past `DATA_LENGTH` set `bad`; the counter saturates.
  - On the `tlast` beat, sample `timestamp` and go to REPORT.
- DROP: `tready`=1; discard beats until `tlast`, then go to IDLE. No counters change.
- REPORT (one cycle), in this order:
  - Length error if the `tlast` beat was not byte `DATA_LENGTH-1`.
  - `frame_count`++.
  - If `bad` or length error: `err_count`++, no RTT update.
  - Else: `rtt_last = sampled_ts - ts` (modulo 2^16, so wrap is handled); `rtt_min`/`rtt_max` update; `rtt_valid`=1.
  - Sequence check (see Configuration).
  - Go to IDLE.

Other rules:
- A frame shorter than 4 bytes is a length error; `idx`/`ts` are not used and the sequence state is unchanged.
- Counters saturate at 16'hFFFF.
- Reset values: all counters 0, `rtt_last` 0, `rtt_min` 16'hFFFF, `rtt_max` 0, `rtt_valid` 0, `busy` 0, state IDLE.
- `s_eth_hdr_ready` and `tready` are 0 while `rst_n` is low.
- Reset asserted mid-frame abandons the frame; after release the block is in IDLE, and any remaining beats of that frame are held back by `tready`=0.

## Timing
- `s_eth_hdr_ready` is registered and high in IDLE only. Header accepted at cycle N → `tready` high from N+1.
- `tready` is held continuously at 1 in RECV/DROP, so payload throughput is 1 byte/cycle.
- The `tlast` beat is accepted at cycle T. At T+1 the block is in REPORT with `rtt_valid`=1 and all outputs updated. At T+2 `s_eth_hdr_ready`=1 again.
- The timestamp used for RTT is the value at cycle T.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RTT_SEQ_CHECK_EN` defined:
  - The first frame with ≥4 bytes after reset arms the check and sets `expected = idx + 1`.
  - Each later such frame: if `idx != expected`, `seq_err_count`++. In either case, `expected = idx + 1`, mod 2^16.
  - Applies to good and bad frames alike.
- Not defined: no sequence logic is built; `seq_err_count` is tied to 0.

## Test plan
- Good frame, idx=5, ts=100, timestamp=130 at `tlast`, `DATA_LENGTH`=256 → `rtt_valid` pulses 1 cycle after `tlast`; `rtt_last`=`rtt_min`=`rtt_max`=30; `frame_count`=1, `err_count`=0.
- Wrap: ts=16'hFFF0, timestamp=16'h0010 → `rtt_last`=32.
- Byte 100 corrupted; then a 255-byte frame; then a frame with `tuser`=1 on its last beat → `err_count`=3, `frame_count`=3, `rtt_valid` never pulses, RTT outputs unchanged.
- Frames with wrong EtherType 16'h0800 and with wrong dest MAC → fully drained, `tready`=1 throughout; all counters unchanged.
- With `RTT_SEQ_CHECK_EN`, idx sequence 7, 8, 10, 11 → `seq_err_count`=1; without the macro → 0.
- `rst_n` pulsed low at payload byte 50 → outputs return to reset values immediately; after release, a fresh good frame is measured correctly.

Source files
------------

// File: rtl/eth_rtt_meter.sv
// Round-trip-time meter for test frames arriving from eth_axis_rx.
// Packet-index sequence checking is built only when RTT_SEQ_CHECK_EN is defined.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a header, s_eth_hdr_ready high
//   RECV   | consuming a matching test frame, checking pattern and length
//   DROP   | draining a frame that is not ours
//   REPORT | one cycle with updated statistics, rtt_valid high if good
module eth_rtt_meter #(
   parameter int          DATA_LENGTH = 256,
   parameter logic [15:0] ETH_TYPE    = 16'h88B6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] local_mac,
   input  logic [15:0] timestamp,
   input  logic        s_eth_hdr_valid,
   output logic        s_eth_hdr_ready,
   input  logic [47:0] s_eth_dest_mac,
   input  logic [47:0] s_eth_src_mac,
   input  logic [15:0] s_eth_type,
   input  logic [7:0]  s_eth_payload_axis_tdata,
   input  logic        s_eth_payload_axis_tvalid,
   output logic        s_eth_payload_axis_tready,
   input  logic        s_eth_payload_axis_tlast,
   input  logic        s_eth_payload_axis_tuser,
   output logic        rtt_valid,
   output logic [15:0] rtt_last,
   output logic [15:0] rtt_min,
   output logic [15:0] rtt_max,
   output logic [15:0] frame_count,
   output logic [15:0] err_count,
   output logic [15:0] seq_err_count,
   output logic        busy
);

   localparam logic [31:0] DLEN     = 32'(DATA_LENGTH);
   localparam logic [15:0] LAST_IDX = 16'(DATA_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, RECV, DROP, REPORT} state_t;

   state_t      state;
   logic [15:0] byte_cnt;
   logic [15:0] idx_q;
   logic [15:0] ts_q;
   logic        bad_q;

   logic        hdr_fire;
   logic        hdr_match;
   logic        beat;
   logic        last_beat;
   logic        beat_err;
   logic        frame_bad;
   logic        len_err;
   logic        has_hdr;
   logic [7:0]  pat_byte;
   logic [15:0] ts_full;
   logic [15:0] rtt_new;
   logic        unused_bits;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      hdr_fire  = s_eth_hdr_valid & s_eth_hdr_ready;
      hdr_match = (s_eth_type == ETH_TYPE) && (s_eth_dest_mac == local_mac);
      beat      = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;
      last_beat = beat & s_eth_payload_axis_tlast;
      pat_byte  = byte_cnt[7:0] + idx_q[7:0];
      beat_err  = s_eth_payload_axis_tuser;
      if ({16'd0, byte_cnt} >= DLEN)
         beat_err = 1'b1;
      else if (byte_cnt >= 16'd4 && s_eth_payload_axis_tdata != pat_byte)
         beat_err = 1'b1;
      frame_bad = bad_q | beat_err;
      len_err   = (byte_cnt != LAST_IDX);
      has_hdr   = (byte_cnt >= 16'd3);
      // With a 4-byte payload the low timestamp byte arrives on the tlast beat itself.
      ts_full   = (byte_cnt == 16'd3) ? {ts_q[15:8], s_eth_payload_axis_tdata} : ts_q;
      rtt_new   = timestamp - ts_full;
   end

   assign unused_bits = ^{s_eth_src_mac, idx_q[15:8]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                     <= IDLE;
         s_eth_hdr_ready           <= 1'b0;
         s_eth_payload_axis_tready <= 1'b0;
         busy                      <= 1'b0;
         byte_cnt                  <= 16'd0;
         idx_q                     <= 16'd0;
         ts_q                      <= 16'd0;
         bad_q                     <= 1'b0;
         rtt_valid                 <= 1'b0;
         rtt_last                  <= 16'd0;
         rtt_min                   <= 16'hFFFF;
         rtt_max                   <= 16'd0;
         frame_count               <= 16'd0;
         err_count                 <= 16'd0;
      end else begin
         rtt_valid <= 1'b0;
         case (state)
            IDLE: begin
               s_eth_hdr_ready <= 1'b1;
               if (hdr_fire) begin
                  s_eth_hdr_ready           <= 1'b0;
                  s_eth_payload_axis_tready <= 1'b1;
                  busy                      <= 1'b1;
                  byte_cnt                  <= 16'd0;
                  bad_q                     <= 1'b0;
                  state                     <= hdr_match ? RECV : DROP;
               end
            end
            RECV: begin
               if (beat) begin
                  case (byte_cnt)
                     16'd0:   idx_q[15:8] <= s_eth_payload_axis_tdata;
                     16'd1:   idx_q[7:0]  <= s_eth_payload_axis_tdata;
                     16'd2:   ts_q[15:8]  <= s_eth_payload_axis_tdata;
                     16'd3:   ts_q[7:0]   <= s_eth_payload_axis_tdata;
                     default: ;
                  endcase
                  byte_cnt <= sat_inc(byte_cnt);
                  bad_q    <= frame_bad;
               end
               // Statistics are committed on the tlast edge so they are visible in REPORT.
               if (last_beat) begin
                  s_eth_payload_axis_tready <= 1'b0;
                  state                     <= REPORT;
                  frame_count               <= sat_inc(frame_count);
                  if (frame_bad || len_err) begin
                     err_count <= sat_inc(err_count);
                  end else begin
                     rtt_valid <= 1'b1;
                     rtt_last  <= rtt_new;
                     if (rtt_new < rtt_min) rtt_min <= rtt_new;
                     if (rtt_new > rtt_max) rtt_max <= rtt_new;
                  end
               end
            end
            DROP: begin
               if (last_beat) begin
                  s_eth_payload_axis_tready <= 1'b0;
                  s_eth_hdr_ready           <= 1'b1;
                  busy                      <= 1'b0;
                  state                     <= IDLE;
               end
            end
            REPORT: begin
               s_eth_hdr_ready <= 1'b1;
               busy            <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RTT_SEQ_CHECK_EN
   logic        seq_armed;
   logic [15:0] seq_expected;

   // Frames too short to carry an index leave the sequence state alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_armed     <= 1'b0;
         seq_expected  <= 16'd0;
         seq_err_count <= 16'd0;
      end else if (state == RECV && last_beat && has_hdr) begin
         if (seq_armed && idx_q != seq_expected)
            seq_err_count <= sat_inc(seq_err_count);
         seq_expected <= idx_q + 16'd1;
         seq_armed    <= 1'b1;
      end
   end
`else
   logic unused_seq;
   assign unused_seq    = has_hdr;
   assign seq_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rtt_meter.sv
// Self-checking bench for eth_rtt_meter: directed scenarios plus randomized frames
// scored against a frame-level reference model.
module tb_eth_rtt_meter;

   localparam int          DL     = 256;
   localparam logic [15:0] ETYPE  = 16'h88B6;
   localparam logic [47:0] MY_MAC = 48'h02_12_34_56_78_9A;
`ifdef RTT_SEQ_CHECK_EN
   localparam int SEQ_EN = 1;
`else
   localparam int SEQ_EN = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [47:0] local_mac = MY_MAC;
   logic [15:0] timestamp = 16'd0;
   logic        s_eth_hdr_valid = 1'b0;
   logic        s_eth_hdr_ready;
   logic [47:0] s_eth_dest_mac = 48'd0;
   logic [47:0] s_eth_src_mac = 48'd0;
   logic [15:0] s_eth_type = 16'd0;
   logic [7:0]  tdata = 8'd0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic        tlast = 1'b0;
   logic        tuser = 1'b0;
   logic        rtt_valid;
   logic [15:0] rtt_last, rtt_min, rtt_max, frame_count, err_count, seq_err_count;
   logic        busy;

   always #4 clk = ~clk;

   eth_rtt_meter #(.DATA_LENGTH(DL), .ETH_TYPE(ETYPE)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .local_mac                 (local_mac),
      .timestamp                 (timestamp),
      .s_eth_hdr_valid           (s_eth_hdr_valid),
      .s_eth_hdr_ready           (s_eth_hdr_ready),
      .s_eth_dest_mac            (s_eth_dest_mac),
      .s_eth_src_mac             (s_eth_src_mac),
      .s_eth_type                (s_eth_type),
      .s_eth_payload_axis_tdata  (tdata),
      .s_eth_payload_axis_tvalid (tvalid),
      .s_eth_payload_axis_tready (tready),
      .s_eth_payload_axis_tlast  (tlast),
      .s_eth_payload_axis_tuser  (tuser),
      .rtt_valid                 (rtt_valid),
      .rtt_last                  (rtt_last),
      .rtt_min                   (rtt_min),
      .rtt_max                   (rtt_max),
      .frame_count               (frame_count),
      .err_count                 (err_count),
      .seq_err_count             (seq_err_count),
      .busy                      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] frm[$];
   logic       usr[$];
   logic obs_v1, obs_hr1, obs_v2, obs_hr2, obs_tr1, obs_busy1, obs_busy2;
   logic obs_stall, obs_timeout;

   // reference model state
   logic [15:0] m_frames, m_errs, m_seqs, m_last, m_min, m_max, m_expd;
   bit          m_armed, m_good;

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic void model_reset();
      m_frames = 0; m_errs = 0; m_seqs = 0; m_last = 0;
      m_min = 16'hFFFF; m_max = 0; m_expd = 0; m_armed = 0; m_good = 0;
   endfunction

   function automatic void model_frame(input logic [15:0] tsamp);
      int n = frm.size();
      bit bad = 0;
      logic [15:0] idx = 0, ts = 0, rtt;
      for (int k = 0; k < n; k++) if (usr[k]) bad = 1;
      if (n > DL) bad = 1;
      if (n >= 4) begin
         idx = {frm[0], frm[1]};
         ts  = {frm[2], frm[3]};
         for (int k = 4; k < n && k < DL; k++)
            if (frm[k] != 8'((k + int'(idx[7:0])) % 256)) bad = 1;
      end
      m_frames = sat(m_frames);
      m_good = !bad && (n == DL);
      if (!m_good) m_errs = sat(m_errs);
      else begin
         rtt = tsamp - ts;
         m_last = rtt;
         if (rtt < m_min) m_min = rtt;
         if (rtt > m_max) m_max = rtt;
      end
      if (SEQ_EN != 0 && n >= 4) begin
         if (m_armed && idx != m_expd) m_seqs = sat(m_seqs);
         m_expd = idx + 16'd1;
         m_armed = 1;
      end
   endfunction

   task automatic make_frame(input logic [15:0] idx, input logic [15:0] ts, input int len);
      frm.delete(); usr.delete();
      for (int k = 0; k < len; k++) begin
         case (k)
            0: frm.push_back(idx[15:8]);
            1: frm.push_back(idx[7:0]);
            2: frm.push_back(ts[15:8]);
            3: frm.push_back(ts[7:0]);
            default: frm.push_back(8'((k + int'(idx[7:0])) % 256));
         endcase
         usr.push_back(1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; s_eth_hdr_valid = 0; tvalid = 0; tlast = 0; tuser = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic send_header(input logic [47:0] dest, input logic [15:0] etype);
      int guard = 0;
      @(negedge clk);
      s_eth_hdr_valid = 1'b1;
      s_eth_dest_mac  = dest;
      s_eth_src_mac   = 48'({$urandom(), $urandom()});
      s_eth_type      = etype;
      while (s_eth_hdr_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      s_eth_hdr_valid = 1'b0;
      if (guard >= 100) obs_timeout = 1'b1;
   endtask

   task automatic send_frame(input logic [47:0] dest, input logic [15:0] etype,
                             input logic [15:0] tsamp, input bit gaps);
      int i = 0;
      int guard = 0;
      int n = frm.size();
      obs_stall = 0; obs_timeout = 0;
      send_header(dest, etype);
      if (obs_timeout) return;
      obs_tr1 = tready; obs_busy1 = busy;
      while (i < n && guard < 4 * n + 64) begin
         if (tready !== 1'b1) obs_stall = 1'b1;
         if (gaps && $urandom_range(7) == 0) begin
            tvalid = 1'b0; tlast = 1'b0; timestamp = 16'($urandom());
         end else begin
            tvalid = 1'b1; tdata = frm[i]; tuser = usr[i]; tlast = (i == n - 1);
            timestamp = (i == n - 1) ? tsamp : 16'($urandom());
            if (tready === 1'b1) i++;
         end
         @(negedge clk);
         guard++;
      end
      if (i < n) obs_timeout = 1'b1;
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; timestamp = 16'($urandom());
      obs_v1 = rtt_valid; obs_hr1 = s_eth_hdr_ready;
      @(negedge clk);
      obs_v2 = rtt_valid; obs_hr2 = s_eth_hdr_ready; obs_busy2 = busy;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({s_eth_hdr_ready, tready} !== 2'b00) begin
         n_bad++; $display("FAIL reset_ready: got %b expected 00", {s_eth_hdr_ready, tready});
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      n_cmp++;
      if ({frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max} !==
          {16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0}) begin
         n_bad++; $display("FAIL reset_stats: got %h %h %h %h %h %h", frame_count, err_count,
                           seq_err_count, rtt_last, rtt_min, rtt_max);
      end
      n_cmp++;
      if ({rtt_valid, busy, tready} !== 3'b000) begin
         n_bad++; $display("FAIL reset_flags: got %b expected 000", {rtt_valid, busy, tready});
      end
      @(negedge clk);
      n_cmp++;
      if (s_eth_hdr_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_hdr_ready: got %b expected 1", s_eth_hdr_ready);
      end
   endtask

   task automatic test_good();
      make_frame(16'd5, 16'd100, DL);
      model_frame(16'd130);
      send_frame(MY_MAC, ETYPE, 16'd130, 1'b0);
      n_cmp++;
      if ({obs_timeout, obs_stall, obs_tr1, obs_busy1} !== 4'b0011) begin
         n_bad++; $display("FAIL good_flow: got %b expected 0011",
                           {obs_timeout, obs_stall, obs_tr1, obs_busy1});
      end
      n_cmp++;
      if ({obs_v1, obs_hr1, obs_v2, obs_hr2, obs_busy2} !== 5'b10010) begin
         n_bad++; $display("FAIL good_timing: got %b expected 10010",
                           {obs_v1, obs_hr1, obs_v2, obs_hr2, obs_busy2});
      end
      n_cmp++;
      if ({rtt_last, rtt_min, rtt_max, frame_count, err_count} !==
          {16'd30, 16'd30, 16'd30, 16'd1, 16'd0}) begin
         n_bad++; $display("FAIL good_rtt: got %0d %0d %0d %0d %0d expected 30 30 30 1 0",
                           rtt_last, rtt_min, rtt_max, frame_count, err_count);
      end
   endtask

   task automatic test_wrap();
      make_frame(16'd6, 16'hFFF0, DL);
      model_frame(16'h0010);
      send_frame(MY_MAC, ETYPE, 16'h0010, 1'b1);
      n_cmp++;
      if ({obs_v1, rtt_last} !== {1'b1, 16'd32}) begin
         n_bad++; $display("FAIL wrap_rtt: got valid=%b rtt=%0d expected valid=1 rtt=32",
                           obs_v1, rtt_last);
      end
      n_cmp++;
      if ({frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max} !==
          {m_frames, m_errs, m_seqs, m_last, m_min, m_max}) begin
         n_bad++; $display("FAIL wrap_stats: got %h %h %h %h %h %h expected %h %h %h %h %h %h",
                           frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max,
                           m_frames, m_errs, m_seqs, m_last, m_min, m_max);
      end
   endtask

   task automatic test_errors();
      logic [15:0] f0 = frame_count, e0 = err_count;
      logic [47:0] rtt0 = {rtt_last, rtt_min, rtt_max};
      bit any_pulse = 0;
      for (int v = 0; v < 3; v++) begin
         case (v)
            0: begin make_frame(16'd7, 16'd200, DL); frm[100] = frm[100] ^ 8'h01; end
            1: make_frame(16'd8, 16'd300, DL - 1);
            default: begin make_frame(16'd9, 16'd400, DL); usr[DL - 1] = 1'b1; end
         endcase
         model_frame(16'd450);
         send_frame(MY_MAC, ETYPE, 16'd450, 1'b0);
         if (obs_v1 || obs_v2 || obs_timeout) any_pulse = 1;
      end
      n_cmp++;
      if ({frame_count, err_count} !== {f0 + 16'd3, e0 + 16'd3}) begin
         n_bad++; $display("FAIL err_counts: got %0d %0d expected %0d %0d",
                           frame_count, err_count, f0 + 16'd3, e0 + 16'd3);
      end
      n_cmp++;
      if (any_pulse !== 1'b0) begin
         n_bad++; $display("FAIL err_no_pulse: got %b expected 0", any_pulse);
      end
      n_cmp++;
      if ({rtt_last, rtt_min, rtt_max} !== rtt0) begin
         n_bad++; $display("FAIL err_rtt_hold: got %h expected %h", {rtt_last, rtt_min, rtt_max}, rtt0);
      end
   endtask

   task automatic test_drop();
      logic [95:0] snap = {frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max};
      for (int v = 0; v < 2; v++) begin
         make_frame(16'd50, 16'd10, DL);
         send_frame((v == 0) ? MY_MAC : (MY_MAC ^ 48'h1), (v == 0) ? 16'h0800 : ETYPE,
                    16'd20, 1'b0);
         n_cmp++;
         if ({obs_timeout, obs_stall, obs_tr1, obs_v1} !== 4'b0010) begin
            n_bad++; $display("FAIL drop_flow%0d: got %b expected 0010", v,
                              {obs_timeout, obs_stall, obs_tr1, obs_v1});
         end
      end
      n_cmp++;
      if ({frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max} !== snap) begin
         n_bad++; $display("FAIL drop_stats: got %h expected %h",
                           {frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max}, snap);
      end
   endtask

   task automatic test_seq();
      logic [15:0] ids[5] = '{16'd7, 16'd8, 16'd99, 16'd10, 16'd11};
      logic [15:0] ts;
      do_reset();
      for (int v = 0; v < 5; v++) begin
         ts = 16'($urandom());
         make_frame(ids[v], ts, (v == 2) ? 2 : DL);
         model_frame(ts + 16'd77);
         send_frame(MY_MAC, ETYPE, ts + 16'd77, 1'b1);
      end
      n_cmp++;
      if ({seq_err_count, err_count, frame_count} !== {16'(SEQ_EN), 16'd1, 16'd5}) begin
         n_bad++; $display("FAIL seq_count: got seq=%0d err=%0d frames=%0d expected %0d 1 5",
                           seq_err_count, err_count, frame_count, SEQ_EN);
      end
      n_cmp++;
      if ({rtt_last, rtt_min, rtt_max} !== {16'd77, 16'd77, 16'd77}) begin
         n_bad++; $display("FAIL seq_rtt: got %0d %0d %0d expected 77 77 77", rtt_last, rtt_min, rtt_max);
      end
   endtask

   task automatic test_random();
      logic [15:0] r_idx = 16'($urandom());
      logic [15:0] ts, tsamp;
      int kind, len, r;
      bit acc;
      for (int f = 0; f < 30; f++) begin
         kind = $urandom_range(9);
         acc = (kind >= 2);
         r = $urandom_range(9);
         len = (r == 0) ? $urandom_range(1, 3) : (r == 1) ? DL - 1 :
               (r == 2) ? DL + $urandom_range(1, 3) : DL;
         if ($urandom_range(4) == 0) r_idx = 16'($urandom());
         ts = 16'($urandom());
         tsamp = ts + 16'($urandom_range(0, 3000));
         make_frame(r_idx, ts, len);
         r_idx = r_idx + 16'd1;
         if (len > 4 && $urandom_range(5) == 0) begin
            r = $urandom_range(4, len - 1);
            frm[r] = frm[r] ^ 8'(1 << $urandom_range(7));
         end
         if ($urandom_range(7) == 0) usr[$urandom_range(0, len - 1)] = 1'b1;
         if (acc) model_frame(tsamp);
         send_frame((kind == 1) ? (MY_MAC ^ 48'h800) : MY_MAC, (kind == 0) ? 16'h86DD : ETYPE,
                    tsamp, $urandom_range(1) == 1);
         n_cmp++;
         if ({frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max} !==
             {m_frames, m_errs, m_seqs, m_last, m_min, m_max}) begin
            n_bad++; $display("FAIL rand_stats%0d: got %h %h %h %h %h %h expected %h %h %h %h %h %h", f,
                              frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max,
                              m_frames, m_errs, m_seqs, m_last, m_min, m_max);
         end
         if (acc) begin
            n_cmp++;
            if ({obs_timeout, obs_stall, obs_v1, obs_hr1, obs_v2, obs_hr2} !==
                {2'b00, m_good, 3'b001}) begin
               n_bad++; $display("FAIL rand_timing%0d: got %b expected %b", f,
                                 {obs_timeout, obs_stall, obs_v1, obs_hr1, obs_v2, obs_hr2},
                                 {2'b00, m_good, 3'b001});
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int i = 0, guard = 0;
      bit leak = 0;
      make_frame(16'd20, 16'd500, DL);
      obs_timeout = 0;
      send_header(MY_MAC, ETYPE);
      while (i < 50 && guard < 200) begin
         tvalid = 1'b1; tdata = frm[i]; tuser = 1'b0; tlast = 1'b0;
         if (tready === 1'b1) i++;
         @(negedge clk);
         guard++;
      end
      tdata = frm[50];
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({obs_timeout, frame_count, err_count, seq_err_count, rtt_last, rtt_min, rtt_max} !==
          {1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0}) begin
         n_bad++; $display("FAIL midreset_stats: got %b %h %h %h %h %h %h", obs_timeout, frame_count,
                           err_count, seq_err_count, rtt_last, rtt_min, rtt_max);
      end
      n_cmp++;
      if ({rtt_valid, busy, tready, s_eth_hdr_ready} !== 4'b0000) begin
         n_bad++; $display("FAIL midreset_flags: got %b expected 0000",
                           {rtt_valid, busy, tready, s_eth_hdr_ready});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         if (tready !== 1'b0 || busy !== 1'b0) leak = 1;
      end
      tvalid = 1'b0;
      n_cmp++;
      if (leak !== 1'b0) begin
         n_bad++; $display("FAIL midreset_holdoff: got tready/busy active=%b expected 0", leak);
      end
      make_frame(16'd21, 16'd1000, DL);
      model_frame(16'd1234);
      send_frame(MY_MAC, ETYPE, 16'd1234, 1'b0);
      n_cmp++;
      if ({obs_timeout, obs_v1, rtt_last, frame_count, err_count} !==
          {1'b0, 1'b1, 16'd234, 16'd1, 16'd0}) begin
         n_bad++; $display("FAIL midreset_fresh: got to=%b v=%b rtt=%0d fc=%0d ec=%0d expected 0 1 234 1 0",
                           obs_timeout, obs_v1, rtt_last, frame_count, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_good();
      test_wrap();
      test_errors();
      test_drop();
      test_seq();
      test_random();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
